image_ycbcr444_ycbcr422: RTL and testbench

- Chroma downsampler that converts per-pixel YCbCr 4:4:4 into the 16-bit 4:2:2 stream {Cb,Y},{Cr,Y},{Cb,Y},…
- Sits directly upstream of the 4:2:2→4:4:4 upsampler; its output word format is that stage's input format.
- Pairs horizontally adjacent pixels and emits one Cb and one Cr per pair, averaged or co-sited per parameter.
- Frame/line syncs pass through with fixed latency; data output cadence is self-timed so gapped input clken is tolerated.

---
 rtl/image_ycbcr444_ycbcr422_if.sv | 23 ++
 rtl/image_ycbcr444_ycbcr422.sv | 68 ++++++
 tb/tb_image_ycbcr444_ycbcr422.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/image_ycbcr444_ycbcr422_if.sv
// image_ycbcr444_ycbcr422_if: video bundle carrying the 4:4:4 input stream and the 4:2:2 output stream
// per_frame_vsync/href/clken, per_img_Y/Cb/Cr : 4:4:4 pixel input (pixel accepted on href & clken)
// post_frame_vsync/href/clken, post_frame_YCbCr : 4:2:2 output, word = {chroma, Y}
interface image_ycbcr444_ycbcr422_if;
  logic        per_frame_vsync;
  logic        per_frame_href;
  logic        per_frame_clken;
  logic [7:0]  per_img_Y;
  logic [7:0]  per_img_Cb;
  logic [7:0]  per_img_Cr;
  logic        post_frame_vsync;
  logic        post_frame_href;
  logic        post_frame_clken;
  logic [15:0] post_frame_YCbCr;
  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y, per_img_Cb, per_img_Cr,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_frame_YCbCr
  );
  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y, per_img_Cb, per_img_Cr,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_frame_YCbCr
  );
endinterface

// File: rtl/image_ycbcr444_ycbcr422.sv
// image_ycbcr444_ycbcr422: pairs adjacent 4:4:4 pixels into a {Cb,Y0},{Cr,Y1} 4:2:2 word stream
// clk, rst_n : pixel clock, asynchronous active-low reset
// vid        : slave side of the video bundle (4:4:4 in, 4:2:2 out, syncs delayed 2 clk)
// CHROMA_AVG : 1 = rounded pair average of chroma, 0 = chroma of the even pixel
module image_ycbcr444_ycbcr422 #(
  parameter bit CHROMA_AVG = 1'b1
) (
  input logic                       clk,
  input logic                       rst_n,
  image_ycbcr444_ycbcr422_if.slave  vid
);
  logic [1:0]  vs_q, vs_d, hs_q, hs_d;
  logic        phase_q, phase_d, pend_q, pend_d, cr_pend_q, cr_pend_d, clken_q, clken_d;
  logic [7:0]  y0_q, y0_d, cb0_q, cb0_d, cr0_q, cr0_d;
  logic [15:0] cr_word_q, cr_word_d, word_q, word_d;
  logic        accept, odd, flush;
  logic [7:0]  cb_pair, cr_pair;
  always_comb begin
    accept    = vid.per_frame_href & vid.per_frame_clken;
    odd       = accept & phase_q;
    // href just fell with an unpaired even pixel: emit it alone as a Cb word
    flush     = ~vid.per_frame_href & hs_q[0] & pend_q;
    cb_pair   = CHROMA_AVG ? 8'((9'(cb0_q) + 9'(vid.per_img_Cb) + 9'd1) >> 1) : cb0_q;
    cr_pair   = CHROMA_AVG ? 8'((9'(cr0_q) + 9'(vid.per_img_Cr) + 9'd1) >> 1) : cr0_q;
    vs_d      = {vs_q[0], vid.per_frame_vsync};
    hs_d      = {hs_q[0], vid.per_frame_href};
    phase_d   = vid.per_frame_href & (accept ? ~phase_q : phase_q);
    pend_d    = vid.per_frame_href & (accept ? ~phase_q : pend_q);
    y0_d      = (accept & ~phase_q) ? vid.per_img_Y  : y0_q;
    cb0_d     = (accept & ~phase_q) ? vid.per_img_Cb : cb0_q;
    cr0_d     = (accept & ~phase_q) ? vid.per_img_Cr : cr0_q;
    // the Cr word goes out one slot after the Cb word; odd accepts are >= 2 clk apart so slots never collide
    cr_pend_d = odd;
    cr_word_d = odd ? {cr_pair, vid.per_img_Y} : cr_word_q;
    clken_d   = odd | flush | cr_pend_q;
    word_d    = odd ? {cb_pair, y0_q} : flush ? {cb0_q, y0_q} : cr_pend_q ? cr_word_q : word_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs_q      <= '0;
      hs_q      <= '0;
      phase_q   <= 1'b0;
      pend_q    <= 1'b0;
      cr_pend_q <= 1'b0;
      clken_q   <= 1'b0;
      y0_q      <= '0;
      cb0_q     <= '0;
      cr0_q     <= '0;
      cr_word_q <= '0;
      word_q    <= '0;
    end else begin
      vs_q      <= vs_d;
      hs_q      <= hs_d;
      phase_q   <= phase_d;
      pend_q    <= pend_d;
      cr_pend_q <= cr_pend_d;
      clken_q   <= clken_d;
      y0_q      <= y0_d;
      cb0_q     <= cb0_d;
      cr0_q     <= cr0_d;
      cr_word_q <= cr_word_d;
      word_q    <= word_d;
    end
  assign vid.post_frame_vsync = vs_q[1];
  assign vid.post_frame_href  = hs_q[1];
  assign vid.post_frame_clken = clken_q;
  assign vid.post_frame_YCbCr = word_q;
endmodule

// File: tb/tb_image_ycbcr444_ycbcr422.sv
// tb_image_ycbcr444_ycbcr422: checks both chroma modes against a line/pair-level reference model
module tb_image_ycbcr444_ycbcr422;
  localparam int N = 4096;
  typedef struct packed { logic [7:0] y, cb, cr; } px_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  image_ycbcr444_ycbcr422_if ia ();
  image_ycbcr444_ycbcr422_if ib ();
  image_ycbcr444_ycbcr422 #(.CHROMA_AVG(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .vid(ia.slave));
  image_ycbcr444_ycbcr422 #(.CHROMA_AVG(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .vid(ib.slave));
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit          e_ce[N];
  logic [15:0] ea[N], eb[N];
  logic        ex_hs[N], ex_vs[N];
  logic [18:0] exp_a[N], exp_b[N], act_a[N], act_b[N];
  px_t         line[$];
  logic        hprev = 1'b0, vprev = 1'b0;
  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    return 8'((int'(a) + int'(b) + 1) / 2);
  endfunction
  task automatic cycle(input logic vs, input logic hs, input logic ce,
                       input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    int k;
    px_t p, p0, p1;
    ia.per_frame_vsync = vs; ia.per_frame_href = hs; ia.per_frame_clken = ce;
    ia.per_img_Y = y; ia.per_img_Cb = cb; ia.per_img_Cr = cr;
    ib.per_frame_vsync = vs; ib.per_frame_href = hs; ib.per_frame_clken = ce;
    ib.per_img_Y = y; ib.per_img_Cb = cb; ib.per_img_Cr = cr;
    @(posedge clk);
    k = cyc;
    cyc++;
    if (!rst_n) begin
      line.delete();
      hprev = 1'b0; vprev = 1'b0;
      e_ce[k] = 1'b0; e_ce[k+1] = 1'b0;
      ex_hs[k] = 1'b0; ex_vs[k] = 1'b0;
      ea[k] = '0; eb[k] = '0;
    end else begin
      ex_hs[k] = hprev;
      ex_vs[k] = vprev;
      if (!hs && hprev && (line.size() % 2 == 1)) begin
        p = line[line.size()-1];
        e_ce[k] = 1'b1; ea[k] = {p.cb, p.y}; eb[k] = {p.cb, p.y};
      end
      if (hs && ce) begin
        p = '{y: y, cb: cb, cr: cr};
        line.push_back(p);
        if (line.size() % 2 == 0) begin
          p0 = line[line.size()-2];
          p1 = line[line.size()-1];
          e_ce[k]   = 1'b1; ea[k]   = {avg(p0.cb, p1.cb), p0.y}; eb[k]   = {p0.cb, p0.y};
          e_ce[k+1] = 1'b1; ea[k+1] = {avg(p0.cr, p1.cr), p1.y}; eb[k+1] = {p0.cr, p1.y};
        end
      end
      if (!hs) line.delete();
      if (!e_ce[k]) begin
        ea[k] = (k > 0) ? ea[k-1] : 16'h0;
        eb[k] = (k > 0) ? eb[k-1] : 16'h0;
      end
      hprev = hs;
      vprev = vs;
    end
    exp_a[k] = {e_ce[k], ex_hs[k], ex_vs[k], ea[k]};
    exp_b[k] = {e_ce[k], ex_hs[k], ex_vs[k], eb[k]};
    #1;
    act_a[k] = {ia.post_frame_clken, ia.post_frame_href, ia.post_frame_vsync, ia.post_frame_YCbCr};
    act_b[k] = {ib.post_frame_clken, ib.post_frame_href, ib.post_frame_vsync, ib.post_frame_YCbCr};
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask
  task automatic test_reset;
    int s;
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    s = 0;
    idle(2);
    rst_n = 1'b1;
    idle(6);
    for (int k = s; k < cyc; k++) begin
      n_cmp += 2;
      if (act_a[k] !== 19'd0) begin n_err++; $display("FAIL reset avg cyc %0d: got %h want 0", k, act_a[k]); end
      if (act_b[k] !== 19'd0) begin n_err++; $display("FAIL reset noavg cyc %0d: got %h want 0", k, act_b[k]); end
    end
  endtask
  task automatic test_line4;
    int s, k0;
    logic [15:0] wa[4], wb[4];
    logic [7:0]  py[4], pcb[4], pcr[4];
    wa = '{16'h650A, 16'hC914, 16'h3C1E, 16'h4B28};
    wb = '{16'h640A, 16'hC814, 16'h321E, 16'h3C28};
    py = '{8'd10, 8'd20, 8'd30, 8'd40};
    pcb = '{8'd100, 8'd101, 8'd50, 8'd70};
    pcr = '{8'd200, 8'd201, 8'd60, 8'd90};
    s = cyc;
    k0 = cyc;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, py[i], pcb[i], pcr[i]);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      n_cmp += 2;
      if ({act_a[k0+1+i][18:17], act_a[k0+1+i][15:0]} !== {2'b11, wa[i]}) begin
        n_err++; $display("FAIL line4 avg word %0d: got %h want %h", i, act_a[k0+1+i][15:0], wa[i]);
      end
      if ({act_b[k0+1+i][18:17], act_b[k0+1+i][15:0]} !== {2'b11, wb[i]}) begin
        n_err++; $display("FAIL line4 noavg word %0d: got %h want %h", i, act_b[k0+1+i][15:0], wb[i]);
      end
    end
    for (int k = s; k < cyc; k++) begin
      n_cmp += 2;
      if (act_a[k] !== exp_a[k]) begin n_err++; $display("FAIL line4 avg cyc %0d: got %h want %h", k, act_a[k], exp_a[k]); end
      if (act_b[k] !== exp_b[k]) begin n_err++; $display("FAIL line4 noavg cyc %0d: got %h want %h", k, act_b[k], exp_b[k]); end
    end
  endtask
  task automatic test_gapped;
    int s, ko;
    s = cyc;
    cycle(1'b0, 1'b1, 1'b1, 8'd0, 8'd255, 8'd255);
    cycle(1'b0, 1'b1, 1'b0, 8'd9, 8'd9, 8'd9);
    cycle(1'b0, 1'b1, 1'b0, 8'd9, 8'd9, 8'd9);
    ko = cyc;
    cycle(1'b0, 1'b1, 1'b1, 8'd0, 8'd254, 8'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'd9, 8'd9, 8'd9);
    cycle(1'b0, 1'b1, 1'b0, 8'd9, 8'd9, 8'd9);
    idle(4);
    n_cmp += 2;
    if ({act_a[ko][18], act_a[ko][15:0]} !== {1'b1, 16'hFF00}) begin
      n_err++; $display("FAIL gapped cb word: got %h want 1ff00", {act_a[ko][18], act_a[ko][15:0]});
    end
    if ({act_a[ko+1][18], act_a[ko+1][15:0]} !== {1'b1, 16'h8000}) begin
      n_err++; $display("FAIL gapped cr word: got %h want 18000", {act_a[ko+1][18], act_a[ko+1][15:0]});
    end
    for (int k = s; k < cyc; k++) begin
      n_cmp += 2;
      if (act_a[k] !== exp_a[k]) begin n_err++; $display("FAIL gapped avg cyc %0d: got %h want %h", k, act_a[k], exp_a[k]); end
      if (act_b[k] !== exp_b[k]) begin n_err++; $display("FAIL gapped noavg cyc %0d: got %h want %h", k, act_b[k], exp_b[k]); end
    end
  endtask
  task automatic test_odd_line;
    int s, k0;
    s = cyc;
    k0 = cyc;
    cycle(1'b0, 1'b1, 1'b1, 8'd1, 8'd16, 8'd16);
    cycle(1'b0, 1'b1, 1'b1, 8'd2, 8'd32, 8'd32);
    cycle(1'b0, 1'b1, 1'b1, 8'd3, 8'd48, 8'd48);
    idle(3);
    cycle(1'b0, 1'b1, 1'b1, 8'd4, 8'd10, 8'd20);
    cycle(1'b0, 1'b1, 1'b1, 8'd5, 8'd30, 8'd40);
    idle(4);
    n_cmp += 3;
    if (act_a[k0+1][15:0] !== 16'h1801) begin n_err++; $display("FAIL odd_line w0: got %h want 1801", act_a[k0+1][15:0]); end
    if (act_a[k0+2][15:0] !== 16'h1802) begin n_err++; $display("FAIL odd_line w1: got %h want 1802", act_a[k0+2][15:0]); end
    if (act_a[k0+3][18:15-15] !== {3'b110, 16'h3003}) begin
      n_err++; $display("FAIL odd_line flush: got %h want 63003", act_a[k0+3]);
    end
    for (int k = s; k < cyc; k++) begin
      n_cmp += 2;
      if (act_a[k] !== exp_a[k]) begin n_err++; $display("FAIL odd_line avg cyc %0d: got %h want %h", k, act_a[k], exp_a[k]); end
      if (act_b[k] !== exp_b[k]) begin n_err++; $display("FAIL odd_line noavg cyc %0d: got %h want %h", k, act_b[k], exp_b[k]); end
    end
  endtask
  task automatic test_midline_reset;
    int s;
    s = cyc;
    cycle(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    cycle(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    cycle(1'b1, 1'b1, 1'b1, 8'd77, 8'd88, 8'd99);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 2;
    if ({ia.post_frame_clken, ia.post_frame_href, ia.post_frame_vsync, ia.post_frame_YCbCr} !== 19'd0) begin
      n_err++; $display("FAIL midline_reset instant avg: got %h want 0", {ia.post_frame_clken, ia.post_frame_href, ia.post_frame_vsync, ia.post_frame_YCbCr});
    end
    if ({ib.post_frame_clken, ib.post_frame_href, ib.post_frame_vsync, ib.post_frame_YCbCr} !== 19'd0) begin
      n_err++; $display("FAIL midline_reset instant noavg: got %h want 0", {ib.post_frame_clken, ib.post_frame_href, ib.post_frame_vsync, ib.post_frame_YCbCr});
    end
    idle(2);
    rst_n = 1'b1;
    idle(2);
    cycle(1'b0, 1'b1, 1'b1, 8'd11, 8'd100, 8'd0);
    cycle(1'b0, 1'b1, 1'b1, 8'd22, 8'd201, 8'd255);
    idle(4);
    for (int k = s; k < cyc; k++) begin
      n_cmp += 2;
      if (act_a[k] !== exp_a[k]) begin n_err++; $display("FAIL midline_reset avg cyc %0d: got %h want %h", k, act_a[k], exp_a[k]); end
      if (act_b[k] !== exp_b[k]) begin n_err++; $display("FAIL midline_reset noavg cyc %0d: got %h want %h", k, act_b[k], exp_b[k]); end
    end
  endtask
  task automatic test_random;
    int s, len, got;
    logic vs;
    s = cyc;
    vs = 1'b0;
    for (int l = 0; l < 40; l++) begin
      if ($urandom_range(0, 5) == 0) vs = ~vs;
      len = $urandom_range(1, 10);
      got = 0;
      while (got < len) begin
        logic ce;
        ce = ($urandom_range(0, 2) != 0);
        cycle(vs, 1'b1, ce, 8'($urandom), 8'($urandom), 8'($urandom));
        if (ce) got++;
      end
      for (int g = $urandom_range(1, 3); g > 0; g--)
        cycle(vs, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    idle(4);
    for (int k = s; k < cyc; k++) begin
      n_cmp += 2;
      if (act_a[k] !== exp_a[k]) begin n_err++; $display("FAIL random avg cyc %0d: got %h want %h", k, act_a[k], exp_a[k]); end
      if (act_b[k] !== exp_b[k]) begin n_err++; $display("FAIL random noavg cyc %0d: got %h want %h", k, act_b[k], exp_b[k]); end
    end
  endtask
  initial begin
    ia.per_frame_vsync = 1'b0; ia.per_frame_href = 1'b0; ia.per_frame_clken = 1'b0;
    ia.per_img_Y = '0; ia.per_img_Cb = '0; ia.per_img_Cr = '0;
    ib.per_frame_vsync = 1'b0; ib.per_frame_href = 1'b0; ib.per_frame_clken = 1'b0;
    ib.per_img_Y = '0; ib.per_img_Cb = '0; ib.per_img_Cr = '0;
    #1;
    n_cmp++;
    if ({ia.post_frame_clken, ia.post_frame_href, ia.post_frame_vsync, ia.post_frame_YCbCr,
         ib.post_frame_clken, ib.post_frame_href, ib.post_frame_vsync, ib.post_frame_YCbCr} !== 38'd0) begin
      n_err++; $display("FAIL reset initial: got %h/%h want 0", ia.post_frame_YCbCr, ib.post_frame_YCbCr);
    end
    test_reset;
    test_line4;
    test_gapped;
    test_odd_line;
    test_midline_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
